// File: rtl/rv_pkg.sv
// Shared definitions for the rv32i core: ALU op codes, forward-select
// encoding and default datapath widths.
package rv_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_EQ  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one source register; MEM wins over WB, and
// x0 never forwards.
module forward_unit
  import rv_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rdM,
  input  logic               regWriteM,
  input  logic [RADDR_W-1:0] rdW,
  input  logic               regWriteW,
  output fwd_sel_t           sel
);

  always_comb begin
    sel = FWD_RF;
    if (regWriteW && (rdW != '0) && (rdW == rs)) sel = FWD_W;
    if (regWriteM && (rdM != '0) && (rdM == rs)) sel = FWD_M;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubbles.
// Define ID_EX_PERF_EN to add bubbleCount/fwdCount performance counters.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               validD,
  input  logic [XLEN-1:0]    rs1DataD,
  input  logic [XLEN-1:0]    rs2DataD,
  input  logic [XLEN-1:0]    immD,
  input  logic [XLEN-1:0]    pcD,
  input  logic [RADDR_W-1:0] rs1D,
  input  logic [RADDR_W-1:0] rs2D,
  input  logic [RADDR_W-1:0] rdD,
  input  logic               useRs1D,
  input  logic               useRs2D,
  input  logic               ALUSrcD,
  input  logic [2:0]         ALUControlD,
  input  logic               regWriteD,
  input  logic               memWriteD,
  input  logic               loadD,
  input  logic               branchD,
  input  logic               flushE,
  input  logic               holdE,
  input  logic [RADDR_W-1:0] rdM,
  input  logic [RADDR_W-1:0] rdW,
  input  logic               regWriteM,
  input  logic               regWriteW,
  input  logic [XLEN-1:0]    resultM,
  input  logic [XLEN-1:0]    resultW,
  output logic               stallD,
  output logic               validE,
  output logic [XLEN-1:0]    srcA,
  output logic [XLEN-1:0]    srcB,
  output logic [2:0]         ALUControlE,
  output logic [XLEN-1:0]    writeDataE,
  output logic [RADDR_W-1:0] rdE,
  output logic [XLEN-1:0]    pcE,
  output logic [XLEN-1:0]    immE,
  output logic               regWriteE,
  output logic               memWriteE,
  output logic               loadE,
  output logic               branchE
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]        bubbleCount,
  output logic [31:0]        fwdCount
`endif
);

  logic               vld_q;
  logic [XLEN-1:0]    rs1_data_q, rs2_data_q, imm_q, pc_q;
  logic [RADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic               alu_src_q;
  logic [2:0]         alu_ctl_q;
  logic               reg_write_q, mem_write_q, load_q, branch_q;

  logic     load_use, bubble;
  fwd_sel_t sel_a, sel_b;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // Load-use is evaluated against the instruction currently in EX.
  assign load_use = vld_q && load_q && reg_write_q && (rd_q != '0) && validD &&
                    ((useRs1D && (rs1D == rd_q)) || (useRs2D && (rs2D == rd_q)));
  assign bubble   = flushE || load_use;
  assign stallD   = load_use && !(flushE && !holdE);

  always_ff @(posedge clk) begin
    if (!rst_n || (!holdE && bubble)) begin
      vld_q       <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_src_q   <= 1'b0;
      alu_ctl_q   <= ALU_ADD;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      load_q      <= 1'b0;
      branch_q    <= 1'b0;
    end else if (!holdE) begin
      vld_q       <= validD;
      rs1_data_q  <= rs1DataD;
      rs2_data_q  <= rs2DataD;
      imm_q       <= immD;
      pc_q        <= pcD;
      rs1_q       <= rs1D;
      rs2_q       <= rs2D;
      rd_q        <= rdD;
      alu_src_q   <= ALUSrcD;
      alu_ctl_q   <= ALUControlD;
      reg_write_q <= regWriteD && validD;
      mem_write_q <= memWriteD && validD;
      load_q      <= loadD && validD;
      branch_q    <= branchD && validD;
    end
  end

  forward_unit #(.RADDR_W(RADDR_W)) u_fwd_a (
    .rs(rs1_q), .rdM(rdM), .regWriteM(regWriteM),
    .rdW(rdW), .regWriteW(regWriteW), .sel(sel_a)
  );

  forward_unit #(.RADDR_W(RADDR_W)) u_fwd_b (
    .rs(rs2_q), .rdM(rdM), .regWriteM(regWriteM),
    .rdW(rdW), .regWriteW(regWriteW), .sel(sel_b)
  );

  always_comb begin
    fwd_a = rs1_data_q;
    fwd_b = rs2_data_q;
    case (sel_a)
      FWD_M:   fwd_a = resultM;
      FWD_W:   fwd_a = resultW;
      default: fwd_a = rs1_data_q;
    endcase
    case (sel_b)
      FWD_M:   fwd_b = resultM;
      FWD_W:   fwd_b = resultW;
      default: fwd_b = rs2_data_q;
    endcase
  end

  assign srcA        = fwd_a;
  assign writeDataE  = fwd_b;
  assign srcB        = alu_src_q ? imm_q : fwd_b;
  assign validE      = vld_q;
  assign ALUControlE = alu_ctl_q;
  assign rdE         = rd_q;
  assign pcE         = pc_q;
  assign immE        = imm_q;
  assign regWriteE   = reg_write_q && vld_q;
  assign memWriteE   = mem_write_q && vld_q;
  assign loadE       = load_q && vld_q;
  assign branchE     = branch_q && vld_q;

`ifdef ID_EX_PERF_EN
  logic any_fwd;
  assign any_fwd = (sel_a != FWD_RF) || (sel_b != FWD_RF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubbleCount <= '0;
      fwdCount    <= '0;
    end else if (!holdE) begin
      if (bubble)           bubbleCount <= bubbleCount + 32'd1;
      if (vld_q && any_fwd) fwdCount    <= fwdCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for capture/forwarding plus
// hand-written load-use, flush and hold sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validD;
  logic [31:0] rs1DataD, rs2DataD, immD, pcD;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        useRs1D, useRs2D, ALUSrcD;
  logic [2:0]  ALUControlD;
  logic        regWriteD, memWriteD, loadD, branchD;
  logic        flushE, holdE;
  logic [4:0]  rdM, rdW;
  logic        regWriteM, regWriteW;
  logic [31:0] resultM, resultW;
  logic        stallD, validE;
  logic [31:0] srcA, srcB, writeDataE, pcE, immE;
  logic [2:0]  ALUControlE;
  logic [4:0]  rdE;
  logic        regWriteE, memWriteE, loadE, branchE;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubbleCount, fwdCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .validD(validD),
    .rs1DataD(rs1DataD), .rs2DataD(rs2DataD), .immD(immD), .pcD(pcD),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .regWriteD(regWriteD), .memWriteD(memWriteD), .loadD(loadD), .branchD(branchD),
    .flushE(flushE), .holdE(holdE), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .resultM(resultM), .resultW(resultW),
    .stallD(stallD), .validE(validE), .srcA(srcA), .srcB(srcB),
    .ALUControlE(ALUControlE), .writeDataE(writeDataE), .rdE(rdE), .pcE(pcE), .immE(immE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .loadE(loadE), .branchE(branchE)
`ifdef ID_EX_PERF_EN
    , .bubbleCount(bubbleCount), .fwdCount(fwdCount)
`endif
  );

  typedef struct {
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alusrc, vld, rw;
    logic [2:0]  ctl;
    logic [4:0]  rdm, rdw;
    logic        rwm, rww;
    logic [31:0] resm, resw;
    logic [31:0] e_srca, e_srcb, e_wd;
    logic        e_vld, e_rw;
    logic [2:0]  e_ctl;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [31:0] rs1d, rs2d, imm, input logic [4:0] rs1, rs2, rd,
    input logic alusrc, vld, rw, input logic [2:0] ctl,
    input logic [4:0] rdm, input logic rwm, input logic [31:0] resm,
    input logic [4:0] rdw, input logic rww, input logic [31:0] resw,
    input logic [31:0] e_srca, e_srcb, e_wd, input logic e_vld, e_rw);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.alusrc = alusrc; v.vld = vld; v.rw = rw; v.ctl = ctl;
    v.rdm = rdm; v.rwm = rwm; v.resm = resm;
    v.rdw = rdw; v.rww = rww; v.resw = resw;
    v.e_srca = e_srca; v.e_srcb = e_srcb; v.e_wd = e_wd;
    v.e_vld = e_vld; v.e_rw = e_rw; v.e_ctl = ctl;
    return v;
  endfunction

  task automatic set_instr(input logic [31:0] r1d, r2d, imm, pc, input logic [4:0] r1, r2, rd,
                           input logic alusrc, ld, rw);
    rs1DataD = r1d; rs2DataD = r2d; immD = imm; pcD = pc;
    rs1D = r1; rs2D = r2; rdD = rd; useRs1D = 1'b1; useRs2D = 1'b1;
    ALUSrcD = alusrc; ALUControlD = 3'b000; validD = 1'b1;
    regWriteD = rw; memWriteD = 1'b0; loadD = ld; branchD = 1'b0;
  endtask

  task automatic clear_fwd();
    rdM = '0; rdW = '0; regWriteM = 1'b0; regWriteW = 1'b0; resultM = '0; resultW = '0;
  endtask

  initial begin
    //            rs1d      rs2d      imm     rs1 rs2 rd  src vld rw ctl   rdm rwm resm       rdw rww resw        srcA      srcB      wd        vld rw
    vecs[0] = mk(32'h11,   32'h22,   32'h100, 1,  2,  3,  0,  1,  1, 3'd0, 0,  0,  32'h0,     0,  0,  32'h0,     32'h11,   32'h22,   32'h22,   1,  1);
    vecs[1] = mk(32'h11,   32'h22,   32'h100, 1,  2,  3,  1,  1,  1, 3'd1, 0,  0,  32'h0,     0,  0,  32'h0,     32'h11,   32'h100,  32'h22,   1,  1);
    vecs[2] = mk(32'h55,   32'h66,   32'h0,   5,  6,  7,  0,  1,  1, 3'd2, 5,  1,  32'h1234,  5,  1,  32'hDEAD,  32'h1234, 32'h66,   32'h66,   1,  1);
    vecs[3] = mk(32'h55,   32'h44,   32'h0,   5,  4,  7,  0,  1,  1, 3'd3, 4,  1,  32'h1234,  5,  1,  32'hDEAD,  32'hDEAD, 32'h1234, 32'h1234, 1,  1);
    vecs[4] = mk(32'h0,    32'h0,    32'h0,   0,  0,  7,  0,  1,  0, 3'd4, 0,  1,  32'hBAD,   0,  1,  32'hBAD1,  32'h0,    32'h0,    32'h0,    1,  0);
    vecs[5] = mk(32'h9,    32'hA,    32'h0,   9,  10, 7,  0,  1,  1, 3'd5, 9,  0,  32'hBAD,   9,  1,  32'h99,    32'h99,   32'hA,    32'hA,    1,  1);
    vecs[6] = mk(32'h77,   32'h88,   32'h0,   1,  2,  7,  0,  0,  1, 3'd0, 0,  0,  32'h0,     0,  0,  32'h0,     32'h77,   32'h88,   32'h88,   0,  0);
    vecs[7] = mk(32'h1,    32'h2,    32'h44,  11, 12, 13, 1,  1,  1, 3'd1, 12, 1,  32'hC0DE,  0,  0,  32'h0,     32'h1,    32'h44,   32'hC0DE, 1,  1);

    rst_n = 1'b0; flushE = 1'b0; holdE = 1'b0;
    clear_fwd();
    set_instr($urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
              1'b1, 1'b1, 1'b1);
    ALUControlD = 3'($urandom);
    tick();
    rs1DataD = $urandom; rs2DataD = $urandom; immD = $urandom; pcD = $urandom;
    tick();
    chk("reset validE", 32'(validE), 32'h0);
    chk("reset srcA", srcA, 32'h0);
    chk("reset srcB", srcB, 32'h0);
    chk("reset ALUControlE", 32'(ALUControlE), 32'h0);
    chk("reset stallD", 32'(stallD), 32'h0);
    chk("reset regWriteE", 32'(regWriteE), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_instr(vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm, 32'(i * 4), vecs[i].rs1, vecs[i].rs2,
                vecs[i].rd, vecs[i].alusrc, 1'b0, vecs[i].rw);
      validD = vecs[i].vld; ALUControlD = vecs[i].ctl;
      rdM = vecs[i].rdm; regWriteM = vecs[i].rwm; resultM = vecs[i].resm;
      rdW = vecs[i].rdw; regWriteW = vecs[i].rww; resultW = vecs[i].resw;
      tick();
      chk($sformatf("v%0d srcA", i), srcA, vecs[i].e_srca);
      chk($sformatf("v%0d srcB", i), srcB, vecs[i].e_srcb);
      chk($sformatf("v%0d writeDataE", i), writeDataE, vecs[i].e_wd);
      chk($sformatf("v%0d validE", i), 32'(validE), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d regWriteE", i), 32'(regWriteE), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d ALUControlE", i), 32'(ALUControlE), 32'(vecs[i].e_ctl));
    end
    clear_fwd();

    // lw x7 -> add x8,x7,x1: one bubble, then forwarded capture
    set_instr(32'h1000, 32'h0, 32'h4, 32'h100, 2, 0, 7, 1'b1, 1'b1, 1'b1);
    useRs2D = 1'b0;
    #1 chk("lu pre stallD", 32'(stallD), 32'h0);
    tick();
    chk("lu lw loadE", 32'(loadE), 32'h1);
    set_instr(32'h0, 32'h5, 32'h0, 32'h104, 7, 1, 8, 1'b0, 1'b0, 1'b1);
    #1 chk("lu stallD", 32'(stallD), 32'h1);
    tick();
    chk("lu bubble validE", 32'(validE), 32'h0);
    chk("lu bubble regWriteE", 32'(regWriteE), 32'h0);
    chk("lu bubble stallD", 32'(stallD), 32'h0);
    rdM = 7; regWriteM = 1'b1; resultM = 32'h7777;
    tick();
    chk("lu add validE", 32'(validE), 32'h1);
    chk("lu add rdE", 32'(rdE), 32'd8);
    chk("lu add srcA", srcA, 32'h7777);
    chk("lu add srcB", srcB, 32'h5);
    chk("lu add stallD", 32'(stallD), 32'h0);
    clear_fwd();

    // flush while load-use condition holds
    set_instr(32'h1000, 32'h0, 32'h4, 32'h200, 2, 0, 7, 1'b1, 1'b1, 1'b1);
    useRs2D = 1'b0;
    tick();
    set_instr(32'h0, 32'h5, 32'h0, 32'h204, 7, 1, 8, 1'b0, 1'b0, 1'b1);
    flushE = 1'b1;
    #1 chk("flush stallD", 32'(stallD), 32'h0);
    tick();
    chk("flush validE", 32'(validE), 32'h0);
    chk("flush regWriteE", 32'(regWriteE), 32'h0);
    chk("flush loadE", 32'(loadE), 32'h0);
    flushE = 1'b0;
    tick();
    chk("post flush validE", 32'(validE), 32'h1);
    chk("post flush pcE", pcE, 32'h204);

    // hold for 3 cycles while decode changes (including a flush request)
    set_instr(32'h31, 32'h32, 32'h33, 32'h300, 3, 4, 9, 1'b0, 1'b0, 1'b1);
    branchD = 1'b1;
    tick();
    holdE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_instr($urandom, $urandom, $urandom, 32'h400 + 32'(k * 4), 5'(20 + k), 5'(21 + k),
                5'(10 + k), 1'b1, 1'b0, 1'b1);
      flushE = (k == 1);
      tick();
      chk($sformatf("hold%0d rdE", k), 32'(rdE), 32'd9);
      chk($sformatf("hold%0d pcE", k), pcE, 32'h300);
      chk($sformatf("hold%0d immE", k), immE, 32'h33);
      chk($sformatf("hold%0d srcA", k), srcA, 32'h31);
      chk($sformatf("hold%0d validE", k), 32'(validE), 32'h1);
      chk($sformatf("hold%0d branchE", k), 32'(branchE), 32'h1);
    end
    holdE = 1'b0;
    tick();
    chk("release rdE", 32'(rdE), 32'd12);
    chk("release pcE", pcE, 32'h408);
    chk("release branchE", 32'(branchE), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the rv32i core.
- Captures decoded operands and control each cycle.
- Resolves RAW hazards by bypassing from EX/MEM and MEM/WB.
- Drives srcA, srcB and ALUControl straight into the ALU.
- Inserts bubbles for load-use and branch flush.

Parameters:
XLEN, 32, datapath width
RADDR_W, 5, register-address width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous, active-low reset
validD  in  1  decode slot holds a real instruction
rs1DataD, rs2DataD  in  XLEN  register-file read data
immD  in  XLEN  sign-extended immediate
pcD  in  XLEN  instruction PC
rs1D, rs2D, rdD  in  RADDR_W  register addresses
useRs1D, useRs2D  in  1  instruction actually reads rs1/rs2
ALUSrcD  in  1  1 = srcB from immediate
ALUControlD  in  3  ALU operation
regWriteD, memWriteD, loadD, branchD  in  1  control bits
flushE  in  1  taken branch; kill the instruction entering EX
holdE  in  1  downstream stall; freeze the stage
rdM, rdW  in  RADDR_W  destination in MEM / WB
regWriteM, regWriteW  in  1  writer valid in MEM / WB
resultM, resultW  in  XLEN  forwardable results
stallD  out  1  load-use stall request to fetch/decode
validE  out  1  EX slot valid
srcA, srcB  out  XLEN  ALU operands
ALUControlE  out  3  ALU operation
writeDataE  out  XLEN  forwarded rs2 for stores
rdE  out  RADDR_W  destination
pcE, immE  out  XLEN  for branch-target computation
regWriteE, memWriteE, loadE, branchE  out  1  control, gated by validE

Behaviour:
- Register update priority per rising edge: rst_n=0 > holdE > flushE > load-use bubble > normal capture.
- Reset: every stage register clears to 0. This gives validE=0, ALUControlE=000, all control outputs 0, rdE=0, pcE=immE=0, and srcA=srcB=0 unless forwarding applies.
- holdE=1: all stage registers keep their value. stallD is still computed. flushE seen during holdE is ignored, so the requester must hold it asserted.
- flushE=1 (with holdE=0): load a bubble. validE=0, and regWrite/memWrite/load/branch are all 0. stallD is forced to 0.
- Load-use:
  - stallD = validE & loadE & regWriteE & (rdE≠0) & validD & ((useRs1D & rs1D==rdE) | (useRs2D & rs2D==rdE)).
  - When asserted, the next edge loads a bubble. Decode must hold its inputs.
  - Exactly one bubble per load-use pair.
- Normal capture: all D inputs are registered. Control bits are ANDed with validD.
- Forwarding, combinational from registered rs1E/rs2E:
  - Select resultM if regWriteM & rdM≠0 & rdM==rsE.
  - Otherwise select resultW if regWriteW & rdW≠0 & rdW==rsE.
  - Otherwise use the registered register-file data. MEM has priority over WB.
- srcA is the forwarded rs1. writeDataE is the forwarded rs2. srcB = ALUSrcE ? immE : forwarded rs2.
- x0 is never forwarded. Address 0 always uses the registered data, which the register file guarantees is 0.
- Latency: one cycle from D inputs to registered outputs. Forward paths have zero latency.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined, add outputs bubbleCount (32) and fwdCount (32):
  - bubbleCount increments on every load-use or flush bubble, but not while holdE=1.
  - fwdCount increments each cycle validE & ~holdE in which any operand is forwarded.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined, the ports and counters are absent, with no functional change.

Decomposition:
- Shared package rv_pkg:
  - ALU op constants: ADD=000, SUB=001, AND=010, OR=011, EQ=100, SLT=101.
  - Forward-select enum: FWD_RF=00, FWD_W=01, FWD_M=10.
  - XLEN and RADDR_W defaults.
- Sub-module forward_unit: purely combinational, instantiated twice (rs1, rs2). Takes rsE, rdM/regWriteM, rdW/regWriteW and returns a 2-bit select.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random D inputs -> validE=0, srcA=0, srcB=0, ALUControlE=000, stallD=0.
- EX/MEM forward: rs1E=5, rdM=5, regWriteM=1, resultM=0x1234, rdW=5, resultW=0xDEAD -> srcA=0x1234.
- Load-use: lw x7 in EX, decode add x8,x7,x1 -> stallD=1 for exactly one cycle. Next cycle validE=0, then the add captures with stallD=0.
- x0: rdM=0, regWriteM=1, rs2E=0, ALUSrcE=0 -> srcB = registered rs2 data (0), not resultM.
- Flush during load-use: flushE=1 and stallD condition true -> stallD=0, bubble loaded, regWriteE=0.
- holdE=1 for 3 cycles while D inputs change -> all E outputs unchanged. On release, capture the current D inputs.
